// File: rtl/rv_mul_pipeline.sv
// ---------------------------------------------------------------------------
// rv_mul_pipeline
//   Fully pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU).
//   Operations enter from execute over a valid/ready handshake together with
//   a destination-register tag, and leave STAGES cycles later with that tag.
//   A single global advance signal stalls every slot at once.
//   flush squashes everything in flight.
//
// Parameters
//   XLEN   : operand/result width (32 or 64)
//   STAGES : pipeline depth = accept-to-result latency (1..8)
//   TAG_W  : width of the pass-through tag
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : operation offered this cycle
//   in_ready   : pipeline accepts this cycle (= advance)
//   in_op      : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a/in_b  : rs1 / rs2 values
//   in_tag     : tag carried to the output
//   flush      : squash all in-flight operations at the next edge
//   out_valid  : result available (registered)
//   out_ready  : consumer accepts result
//   out_result : selected product slice (registered)
//   out_tag    : tag of the result (registered)
//   busy       : at least one slot holds a valid operation
// ---------------------------------------------------------------------------
module rv_mul_pipeline #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Extending both operands to the full 2*XLEN width makes a plain
    // truncated multiply equal to the signed (XLEN+1)x(XLEN+1) product
    // modulo 2^(2*XLEN), which is all the four opcodes ever look at.
    function automatic logic [XLEN-1:0] mul_slice(
        input logic [1:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic                a_sgn;
        logic                b_sgn;
        logic [2*XLEN-1:0]   a_ext;
        logic [2*XLEN-1:0]   b_ext;
        logic [2*XLEN-1:0]   prod;
        a_sgn = (op != OP_MULHU) & a[XLEN-1];
        b_sgn = ((op == OP_MUL) | (op == OP_MULH)) & b[XLEN-1];
        a_ext = {{XLEN{a_sgn}}, a};
        b_ext = {{XLEN{b_sgn}}, b};
        prod  = a_ext * b_ext;
        case (op)
            OP_MUL:    mul_slice = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  mul_slice = prod[2*XLEN-1:XLEN];
            default:   mul_slice = prod[2*XLEN-1:XLEN];
        endcase
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [XLEN-1:0]   data_r [STAGES];
    logic [TAG_W-1:0]  tag_r  [STAGES];
    logic              adv_s;
    logic [XLEN-1:0]   prod_s;

    // The product is formed in front of slot 0; the remaining slots give the
    // synthesis tool registers to retime the multiplier array across.
    assign prod_s = mul_slice(in_op, in_a, in_b);

    // Global advance: the whole pipe moves unless the output is held.
    assign adv_s    = !valid_r[STAGES-1] || out_ready;
    assign in_ready = adv_s;

    assign out_valid  = valid_r[STAGES-1];
    assign out_result = data_r[STAGES-1];
    assign out_tag    = tag_r[STAGES-1];
    assign busy       = |valid_r;

    // Slot valid bits: flush overrides stall; a bubble enters when in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
        end else if (flush) begin
            valid_r <= {STAGES{1'b0}};
        end else if (adv_s) begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Slot data and tags: shift on advance, hold otherwise; flush leaves them as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= {XLEN{1'b0}};
                tag_r[i]  <= {TAG_W{1'b0}};
            end
        end else if (adv_s) begin
            data_r[0] <= prod_s;
            tag_r[0]  <= in_tag;
            for (int i = 1; i < STAGES; i++) begin
                data_r[i] <= data_r[i-1];
                tag_r[i]  <= tag_r[i-1];
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                data_r[i] <= data_r[i];
                tag_r[i]  <= tag_r[i];
            end
        end
    end

endmodule

// File: tb/tb_rv_mul_pipeline.sv
// ---------------------------------------------------------------------------
// tb_rv_mul_pipeline
//   Scoreboard bench. Drivers push the expected response when an operation
//   is accepted; independent monitors pop and compare on each output
//   handshake. One 32-bit STAGES=3 instance runs the directed scenarios.
//   Three 64-bit instances (STAGES 1, 2, 8) run against a reference model
//   built from an unsigned product with sign corrections.
// ---------------------------------------------------------------------------
module tb_rv_mul_pipeline;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] cyc;
    logic        sweep_go;
    int          tests;
    int          fails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- main 32-bit instance ----------------
    logic        m_in_valid;
    logic        m_in_ready;
    logic [1:0]  m_in_op;
    logic [31:0] m_in_a;
    logic [31:0] m_in_b;
    logic [4:0]  m_in_tag;
    logic        m_flush;
    logic        m_out_valid;
    logic        m_out_ready;
    logic [31:0] m_out_result;
    logic [4:0]  m_out_tag;
    logic        m_busy;
    exp_t        mq[$];

    rv_mul_pipeline #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_main (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (m_in_valid),
        .in_ready   (m_in_ready),
        .in_op      (m_in_op),
        .in_a       (m_in_a),
        .in_b       (m_in_b),
        .in_tag     (m_in_tag),
        .flush      (m_flush),
        .out_valid  (m_out_valid),
        .out_ready  (m_out_ready),
        .out_result (m_out_result),
        .out_tag    (m_out_tag),
        .busy       (m_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Offer one operation; push the expectation in the cycle it is accepted.
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] res, input logic lat);
        exp_t e;
        int   n;
        m_in_valid = 1'b1;
        m_in_op    = op;
        m_in_a     = a;
        m_in_b     = b;
        m_in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!m_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!m_in_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: tag %0d in_ready=%0b required 1", tag, m_in_ready);
        end else begin
            e.res = {32'd0, res};
            e.tag = tag;
            e.lat = lat;
            e.cyc = cyc;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
    endtask

    // Main monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_out_valid && m_out_ready) begin
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL main_unexpected: got tag %0d result %h required no output",
                             m_out_tag, m_out_result);
                end else begin
                    e = mq.pop_front();
                    chk("main_result", {32'd0, m_out_result}, e.res);
                    chk("main_tag", 64'(m_out_tag), 64'(e.tag));
                    if (e.lat) chk("main_latency", 64'(cyc - e.cyc), 64'd3);
                end
            end
        end
    end

    // ---------------- 64-bit sweep instances ----------------
    function automatic logic [63:0] ref64(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] u;
        logic [63:0]  hi;
        u  = {64'd0, a} * {64'd0, b};
        hi = u[127:64];
        case (op)
            2'b00:   ref64 = u[63:0];
            2'b01:   ref64 = hi - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
            2'b10:   ref64 = hi - (a[63] ? b : 64'd0);
            default: ref64 = hi;
        endcase
    endfunction

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 7))
            0:       pick64 = 64'd0;
            1:       pick64 = 64'd1;
            2:       pick64 = 64'hFFFF_FFFF_FFFF_FFFF;
            3:       pick64 = 64'h8000_0000_0000_0000;
            4:       pick64 = 64'h7FFF_FFFF_FFFF_FFFF;
            default: pick64 = {$urandom, $urandom};
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);
        logic        in_valid = 1'b0;
        logic        in_ready;
        logic [1:0]  op = 2'b00;
        logic [63:0] a = 64'd0;
        logic [63:0] b = 64'd0;
        logic [4:0]  tag = 5'd0;
        logic        flush = 1'b0;
        logic        out_valid;
        logic        out_ready = 1'b1;
        logic [63:0] out_result;
        logic [4:0]  out_tag;
        logic        busy;
        logic        phase_b = 1'b0;
        logic        done = 1'b0;
        int          got = 0;
        exp_t        q[$];

        rv_mul_pipeline #(.XLEN(64), .STAGES(ST), .TAG_W(5)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_op      (op),
            .in_a       (a),
            .in_b       (b),
            .in_tag     (tag),
            .flush      (flush),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_result (out_result),
            .out_tag    (out_tag),
            .busy       (busy)
        );

        initial begin
            forever begin
                @(posedge clk);
                #1;
                out_ready = phase_b ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end

        initial begin
            exp_t e;
            int   w;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int n = 0; n < 1000; n++) begin
                if (n == 300) begin
                    // Let unstalled traffic drain so its latency stays exact.
                    w = 0;
                    while (q.size() != 0 && w < 50) begin
                        w++;
                        @(posedge clk);
                    end
                    #1;
                    phase_b = 1'b1;
                end
                if ($urandom_range(0, 4) == 0) begin
                    @(posedge clk);
                    #1;
                end
                op       = 2'($urandom_range(0, 3));
                a        = pick64();
                b        = pick64();
                tag      = n[4:0];
                in_valid = 1'b1;
                w = 0;
                @(negedge clk);
                while (!in_ready && w < 200) begin
                    w++;
                    @(negedge clk);
                end
                if (!in_ready) begin
                    tests++;
                    fails++;
                    $display("FAIL sweep%0d_issue_timeout: in_ready=%0b required 1", ST, in_ready);
                end else begin
                    e.res = ref64(op, a, b);
                    e.tag = tag;
                    e.lat = !phase_b;
                    e.cyc = cyc;
                    q.push_back(e);
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            w = 0;
            while (q.size() != 0 && w < 200) begin
                w++;
                @(posedge clk);
            end
            @(negedge clk);
            chk($sformatf("sweep%0d_count", ST), 64'(got), 64'd1000);
            done = 1'b1;
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sweep%0d_unexpected: got tag %0d required no output",
                                 ST, out_tag);
                    end else begin
                        e = q.pop_front();
                        got++;
                        tests++;
                        if (out_result !== e.res || out_tag !== e.tag) begin
                            fails++;
                            $display("FAIL sweep%0d_result: got %h/tag %0d required %h/tag %0d",
                                     ST, out_result, out_tag, e.res, e.tag);
                        end
                        if (e.lat) chk($sformatf("sweep%0d_latency", ST), 64'(cyc - e.cyc), 64'(ST));
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        tests       = 0;
        fails       = 0;
        sweep_go    = 1'b0;
        rst         = 1'b0;
        m_in_valid  = 1'b0;
        m_in_op     = 2'b00;
        m_in_a      = 32'd0;
        m_in_b      = 32'd0;
        m_in_tag    = 5'd0;
        m_flush     = 1'b0;
        m_out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_out_result", 64'(m_out_result), 64'd0);
        chk("rst_out_tag", 64'(m_out_tag), 64'd0);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_in_ready", 64'(m_in_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic MUL then back-to-back signed corner cases, exact latency 3.
        issue32(2'b00, 32'd7, 32'd6, 5'd3, 32'h0000_002A, 1'b1);
        issue32(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b1);
        issue32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1'b1);
        issue32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b1);
        issue32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 1'b1);
        issue32(2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd8, 32'h3FFF_FFFF, 1'b1);
        issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 1'b1);
        issue32(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 1'b1);
        issue32(2'b11, 32'h8000_0000, 32'h0000_0002, 5'd11, 32'h0000_0001, 1'b1);
        issue32(2'b00, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h0000_0000, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("idle_busy", 64'(m_busy), 64'd0);

        // Backpressure: output held for 5 cycles, then drains in order.
        issue32(2'b00, 32'd1, 32'h100, 5'd1, 32'h0000_0100, 1'b0);
        issue32(2'b00, 32'd2, 32'h100, 5'd2, 32'h0000_0200, 1'b0);
        issue32(2'b00, 32'd3, 32'h100, 5'd3, 32'h0000_0300, 1'b0);
        m_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(m_in_ready), 64'd0);
            chk("stall_out_tag", 64'(m_out_tag), 64'd1);
            chk("stall_out_result", 64'(m_out_result), 64'h100);
        end
        @(posedge clk);
        #1 m_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain_queue_empty", 64'(mq.size()), 64'd0);
        chk("drain_busy", 64'(m_busy), 64'd0);

        // Flush in the cycle tag 4 is offered; tag 1 is handshaken that cycle.
        issue32(2'b00, 32'd1, 32'd11, 5'd1, 32'd11, 1'b1);
        issue32(2'b00, 32'd2, 32'd11, 5'd2, 32'd22, 1'b1);
        issue32(2'b00, 32'd3, 32'd11, 5'd3, 32'd33, 1'b1);
        m_in_valid = 1'b1;
        m_in_op    = 2'b00;
        m_in_a     = 32'd4;
        m_in_b     = 32'd11;
        m_in_tag   = 5'd4;
        m_flush    = 1'b1;
        @(posedge clk);
        #1;
        m_flush    = 1'b0;
        m_in_valid = 1'b0;
        mq.delete();
        @(negedge clk);
        chk("flush_busy", 64'(m_busy), 64'd0);
        chk("flush_out_valid", 64'(m_out_valid), 64'd0);
        repeat (8) @(posedge clk);
        #1;

        // Asynchronous reset with two operations in flight.
        m_out_ready = 1'b0;
        issue32(2'b00, 32'd9, 32'd9, 5'd7, 32'h51, 1'b1);
        issue32(2'b00, 32'd8, 32'd8, 5'd8, 32'h40, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", 64'(m_out_valid), 64'd1);
        chk("pre_reset_out_tag", 64'(m_out_tag), 64'd7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("async_rst_out_result", 64'(m_out_result), 64'd0);
        chk("async_rst_out_tag", 64'(m_out_tag), 64'd0);
        chk("async_rst_busy", 64'(m_busy), 64'd0);
        chk("async_rst_in_ready", 64'(m_in_ready), 64'd1);
        mq.delete();
        rst = 1'b0;
        m_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_out_valid", 64'(m_out_valid), 64'd0);
        issue32(2'b00, 32'd3, 32'd5, 5'd9, 32'h0000_000F, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_queue_empty", 64'(mq.size()), 64'd0);

        // Parameter sweep on the 64-bit instances.
        sweep_go = 1'b1;
        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && n < 20000) begin
            n++;
            @(posedge clk);
        end
        chk("sweep_done", 64'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_mul_pipeline.md
Name: rv_mul_pipeline

Overview:
Parametrised, fully pipelined RV32M/RV64M integer multiplier for the RISC-V core pipeline. It executes MUL, MULH, MULHSU and MULHU.
- Inputs arrive from the execute stage over a valid/ready handshake, carrying a destination-register tag.
- Results are returned STAGES cycles later with the same tag.
- Supports global stall (backpressure) and synchronous flush for branch/exception squash.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64).
STAGES, 3, pipeline depth and accept-to-result latency in cycles; legal range 1..8.
TAG_W, 5, width of the pass-through tag (rd index).

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operation offered this cycle.
in_ready  output  1  pipeline can accept this cycle.
in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
in_a  input  XLEN  rs1 value.
in_b  input  XLEN  rs2 value.
in_tag  input  TAG_W  tag carried to output.
flush  input  1  squash all in-flight operations.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_result  output  XLEN  product slice per op.
out_tag  output  TAG_W  tag of the result.
busy  output  1  at least one operation in flight.

Behaviour:
- Reset: asynchronous, active-high. All per-stage valid bits clear, and all data/tag registers clear to 0. While in reset: out_valid=0, out_result=0, out_tag=0, busy=0, in_ready=1.
- Structure: STAGES register slots, each holding valid, op, tag and intermediate data. Slot STAGES-1 drives the outputs directly (registered outputs, no combinational path from inputs to out_*).
- Advance rule: adv = !out_valid || out_ready. When adv=1 every slot shifts by one; when adv=0 all slots hold (global stall, no bubble collapse). in_ready = adv.
- Accept: an operation is accepted when in_valid && in_ready && !flush. It occupies slot 0 on the next edge. If in_valid=0 while adv=1, slot 0 loads a bubble (valid=0).
- Latency and throughput: with no stall, an operation accepted at edge N has out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following the STAGES-th edge counted from accept. Throughput is one operation per cycle.
- Hold: while out_valid && !out_ready, out_result and out_tag remain stable.
- Arithmetic: extend each operand to XLEN+1 bits and form the signed 2*XLEN-bit product P.
  - in_a is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - in_b is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
  - MUL returns P[XLEN-1:0]; all others return P[2*XLEN-1:XLEN].
  - How partial products are split across stages is implementation choice, but results must be bit-exact for every STAGES value.
- Flush: synchronous, highest priority. On a cycle with flush=1, every valid bit clears at the next edge regardless of adv, and the input offered that cycle is not accepted. Data registers need not clear. out_valid=0 and busy=0 from the next cycle. A result handshaken (out_valid && out_ready) in the same cycle as flush counts as delivered.
- busy: OR of all slot valid bits.
- Reset asserted mid-operation: all in-flight operations are discarded immediately; no output is produced after reset release until new accepts occur.
- STAGES=1: a single register; in_ready = !out_valid || out_ready, so full rate is still achieved with out_ready=1.

Test Plan:
1. STAGES=3, out_ready=1. Issue MUL 7×6 tag 3 at cycle 0 → out_valid after 3 edges with result 0x0000002A, tag 3. Back-to-back issues on consecutive cycles produce consecutive outputs.
2. Signed corner cases:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
3. Backpressure: fill the pipe with tags 1,2,3, hold out_ready=0 for 5 cycles → in_ready=0 throughout, out_tag stays 1 with a stable result. On release, tags 1,2,3 emerge on consecutive cycles with no loss or duplication.
4. Flush: issue tags 1..3, assert flush in the cycle tag 4 is offered → busy=0 and out_valid=0 the next cycle. Tag 4 never appears; no flushed tag ever appears.
5. Async reset mid-stream with 2 operations in flight → outputs zero immediately with no clock edge required; after release, a fresh MUL 3×5 returns 0x0000000F at the normal latency.
6. Parameter sweep: STAGES∈{1,2,8}, XLEN=64, randomised ops against a reference model → 1000 results bit-exact, latency equals STAGES.
